// File: rtl/cafea_credit.sv
// cafea_credit: payment and selection front-end for the coffee FSM.
// Synchronises raw coin/button inputs, accumulates credit, sells drinks by
// issuing one-cycle B1/B2/B3 pulses, refunds change on cancel, and restores
// the price of a drink the downstream FSM never acknowledges via busy.
//
// Ports:
//   clk                      rising-edge system clock
//   reset                    asynchronous active-low reset
//   coin5, coin10            raw coin sensor levels (asynchronous)
//   sel1, sel2, sel3         raw drink buttons (asynchronous)
//   cancel                   raw cancel/refund button (asynchronous)
//   busy                     coffee FSM brewing indication (synchronous)
//   B1, B2, B3               one-cycle selection pulses to the FSM
//   credit                   current credit (unsigned)
//   change_pulse             one pulse per CHANGE_UNIT returned
//   coin_reject              one-cycle pulse when a coin is refused
//   err                      one-cycle pulse on a busy timeout
module cafea_credit #(
    parameter int unsigned PRICE1      = 10,
    parameter int unsigned PRICE2      = 15,
    parameter int unsigned PRICE3      = 20,
    parameter int unsigned CREDIT_MAX  = 50,
    parameter int unsigned CHANGE_UNIT = 5,
    parameter int unsigned TIMEOUT     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin5,
    input  logic       coin10,
    input  logic       sel1,
    input  logic       sel2,
    input  logic       sel3,
    input  logic       cancel,
    input  logic       busy,
    output logic       B1,
    output logic       B2,
    output logic       B3,
    output logic [7:0] credit,
    output logic       change_pulse,
    output logic       coin_reject,
    output logic       err
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StRefund
    } state_e;

    state_e          r_state;
    logic [5:0]      r_sync1;
    logic [5:0]      r_sync2;
    logic [5:0]      r_sync3;
    logic            r_pend5;
    logic [1:0]      r_sel;
    logic [7:0]      r_credit;
    logic [CntW-1:0] r_cnt;
    logic            r_phase;
    logic            r_b1;
    logic            r_b2;
    logic            r_b3;
    logic            r_change;
    logic            r_reject;
    logic            r_err;

    logic [5:0] w_raw;
    logic [5:0] w_ev;
    logic       w_coin_req;
    logic [9:0] w_coin_val;
    logic [9:0] w_coin_sum;
    logic       w_coin_ok;
    logic       w_pend5_d;
    logic [9:0] w_base;
    logic [1:0] w_pick;

    // Bit order: {cancel, sel3, sel2, sel1, coin10, coin5}
    assign w_raw = {cancel, sel3, sel2, sel1, coin10, coin5};

    // Two synchroniser flops plus one history flop; events fire on a 0->1 of
    // the synchronised level, so a held button yields a single event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_ev = r_sync2 & ~r_sync3;

    function automatic logic [9:0] price_of(input logic [1:0] n);
        case (n)
            2'd1:    price_of = 10'(PRICE1);
            2'd2:    price_of = 10'(PRICE2);
            2'd3:    price_of = 10'(PRICE3);
            default: price_of = 10'd0;
        endcase
    endfunction

    function automatic logic [7:0] sat8(input logic [9:0] v);
        sat8 = (v > 10'd255) ? 8'hFF : v[7:0];
    endfunction

    // Coin handling: coin10 wins a simultaneous insertion and coin5 is held
    // one cycle in r_pend5. Coins are dropped entirely while refunding.
    always_comb begin
        w_coin_req = 1'b0;
        w_coin_val = 10'd0;
        w_pend5_d  = 1'b0;
        if (r_state != StRefund) begin
            if (w_ev[1]) begin
                w_coin_req = 1'b1;
                w_coin_val = 10'd10;
                w_pend5_d  = w_ev[0];
            end else if (w_ev[0] || r_pend5) begin
                w_coin_req = 1'b1;
                w_coin_val = 10'd5;
            end
        end
        w_coin_sum = {2'b00, r_credit} + w_coin_val;
        w_coin_ok  = w_coin_req && (w_coin_sum <= 10'(CREDIT_MAX));
        w_base     = w_coin_ok ? w_coin_sum : {2'b00, r_credit};
    end

    // Selection priority sel1 > sel2 > sel3; 0 means no selection.
    always_comb begin
        w_pick = 2'd0;
        if (w_ev[2]) begin
            w_pick = 2'd1;
        end else if (w_ev[3]) begin
            w_pick = 2'd2;
        end else if (w_ev[4]) begin
            w_pick = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= StIdle;
            r_pend5  <= 1'b0;
            r_sel    <= 2'd0;
            r_credit <= 8'd0;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
            r_b1     <= 1'b0;
            r_b2     <= 1'b0;
            r_b3     <= 1'b0;
            r_change <= 1'b0;
            r_reject <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_b1     <= 1'b0;
            r_b2     <= 1'b0;
            r_b3     <= 1'b0;
            r_change <= 1'b0;
            r_err    <= 1'b0;
            r_reject <= w_coin_req && !w_coin_ok;
            r_pend5  <= w_pend5_d;
            r_credit <= sat8(w_base);
            case (r_state)
                StIdle: begin
                    if (w_ev[5] && (r_credit != 8'd0)) begin
                        r_state <= StRefund;
                        r_phase <= 1'b0;
                    end else if ((w_pick != 2'd0) &&
                                 ({2'b00, r_credit} >= price_of(w_pick))) begin
                        r_credit <= sat8(w_base - price_of(w_pick));
                        r_sel    <= w_pick;
                        r_state  <= StIssue;
                    end
                end
                StIssue: begin
                    r_b1    <= (r_sel == 2'd1);
                    r_b2    <= (r_sel == 2'd2);
                    r_b3    <= (r_sel == 2'd3);
                    r_cnt   <= '0;
                    r_state <= StWaitBusy;
                end
                StWaitBusy: begin
                    if (busy) begin
                        r_state <= StWaitDone;
                    end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
                        // FSM never took the order: give the money back.
                        r_credit <= sat8(w_base + price_of(r_sel));
                        r_err    <= 1'b1;
                        r_state  <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (!busy) begin
                        r_state <= StIdle;
                    end
                end
                StRefund: begin
                    if (r_phase) begin
                        r_phase <= 1'b0;
                    end else if (r_credit < 8'(CHANGE_UNIT)) begin
                        r_credit <= 8'd0;
                        r_state  <= StIdle;
                    end else begin
                        r_credit <= r_credit - 8'(CHANGE_UNIT);
                        r_change <= 1'b1;
                        r_phase  <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign B1           = r_b1;
    assign B2           = r_b2;
    assign B3           = r_b3;
    assign credit       = r_credit;
    assign change_pulse = r_change;
    assign coin_reject  = r_reject;
    assign err          = r_err;

endmodule

// File: tb/tb_cafea_credit.sv
// Testbench for cafea_credit: a transaction-level credit model predicts the
// sequence of observable events (any output pulse or credit change); a
// separate monitor pops and compares each event the DUT presents.
module tb_cafea_credit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       coin5 = 1'b0;
    logic       coin10 = 1'b0;
    logic       sel1 = 1'b0;
    logic       sel2 = 1'b0;
    logic       sel3 = 1'b0;
    logic       cancel = 1'b0;
    logic       busy = 1'b0;
    logic       B1;
    logic       B2;
    logic       B3;
    logic [7:0] credit;
    logic       change_pulse;
    logic       coin_reject;
    logic       err;

    cafea_credit dut (
        .clk          (clk),
        .reset        (reset),
        .coin5        (coin5),
        .coin10       (coin10),
        .sel1         (sel1),
        .sel2         (sel2),
        .sel3         (sel3),
        .cancel       (cancel),
        .busy         (busy),
        .B1           (B1),
        .B2           (B2),
        .B3           (B3),
        .credit       (credit),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Pulse vector order: {B1, B2, B3, change_pulse, coin_reject, err}
    localparam logic [5:0] PB1  = 6'b100000;
    localparam logic [5:0] PB2  = 6'b010000;
    localparam logic [5:0] PB3  = 6'b001000;
    localparam logic [5:0] PCH  = 6'b000100;
    localparam logic [5:0] PREJ = 6'b000010;
    localparam logic [5:0] PERR = 6'b000001;

    typedef struct packed {
        logic [5:0] p;
        logic [7:0] c;
    } ev_t;

    ev_t        exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         m_credit = 0;
    logic [7:0] prev_credit = 8'd0;
    bit         mon_en = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic int price(input int n);
        case (n)
            1:       return 10;
            2:       return 15;
            default: return 20;
        endcase
    endfunction

    function automatic logic [5:0] bpulse(input int n);
        case (n)
            1:       return PB1;
            2:       return PB2;
            default: return PB3;
        endcase
    endfunction

    task automatic push(input logic [5:0] p, input int c);
        ev_t e;
        e.p = p;
        e.c = 8'(c);
        exp_q.push_back(e);
    endtask

    task automatic model_coin(input int v);
        if (m_credit + v <= 50) begin
            m_credit += v;
            push(6'b0, m_credit);
        end else begin
            push(PREJ, m_credit);
        end
    endtask

    // Mask order: {cancel, sel3, sel2, sel1, coin10, coin5}
    task automatic drive(input logic [5:0] m);
        {cancel, sel3, sel2, sel1, coin10, coin5} = m;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: an event is any output pulse or a change of credit.
    always @(negedge clk) begin : monitor
        ev_t obs;
        ev_t e;
        if (mon_en) begin
            obs.p = {B1, B2, B3, change_pulse, coin_reject, err};
            obs.c = credit;
            if (obs.p != 6'b0 || credit != prev_credit) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: got pulses=%b credit=%0d want none",
                             obs.p, obs.c);
                end else begin
                    e = exp_q.pop_front();
                    if (e != obs) begin
                        bad++;
                        $display("FAIL event: got pulses=%b credit=%0d want pulses=%b credit=%0d",
                                 obs.p, obs.c, e.p, e.c);
                    end
                end
            end
            prev_credit = credit;
        end
    end

    task automatic act_coin(input bit c5, input bit c10);
        int hold;
        hold = $urandom_range(1, 8);
        if (c10) model_coin(10);
        if (c5) model_coin(5);
        drive({4'b0000, c10, c5});
        repeat (hold) @(negedge clk);
        drive(6'b0);
        settle(30);
        check("coin_queue_drained", exp_q.size(), 0);
    endtask

    task automatic act_sel(input logic [2:0] sel, input bit cncl, input bit respond,
                           input int busy_len, input bit inject);
        int n;
        int hold;
        int blen;
        bit acc;
        bit seen;
        n    = 0;
        acc  = 1'b0;
        seen = 1'b0;
        blen = busy_len;
        hold = $urandom_range(1, 6);
        if (cncl && m_credit > 0) begin
            while (m_credit >= 5) begin
                m_credit -= 5;
                push(PCH, m_credit);
            end
            if (m_credit > 0) begin
                m_credit = 0;
                push(6'b0, 0);
            end
        end else begin
            n = sel[0] ? 1 : sel[1] ? 2 : sel[2] ? 3 : 0;
            if (n != 0 && m_credit >= price(n)) begin
                acc = 1'b1;
                m_credit -= price(n);
                push(6'b0, m_credit);
                push(bpulse(n), m_credit);
                if (!respond) begin
                    m_credit += price(n);
                    if (m_credit > 255) m_credit = 255;
                    push(PERR, m_credit);
                end
            end
        end
        drive({cncl, sel, 2'b00});
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == hold - 1) drive(6'b0);
            if (acc && (B1 || B2 || B3)) begin
                seen = 1'b1;
                break;
            end
        end
        drive(6'b0);
        if (acc) check("b_pulse_seen", seen, 1);
        if (acc && respond && seen) begin
            busy = 1'b1;
            if (inject) begin
                // coin5 and sel1 while the FSM is brewing
                repeat (3) @(negedge clk);
                model_coin(5);
                drive(6'b000101);
                repeat (2) @(negedge clk);
                drive(6'b0);
                blen -= 5;
            end
            repeat (blen) @(negedge clk);
            busy = 1'b0;
        end
        settle(50);
        check("sel_queue_drained", exp_q.size(), 0);
    endtask

    task automatic reset_mid_refund();
        bit seen;
        int c;
        seen = 1'b0;
        if (m_credit > 0) act_sel(3'b000, 1'b1, 1'b0, 0, 1'b0);
        repeat (5) act_coin(1'b0, 1'b1);
        c = m_credit;
        while (c >= 5) begin
            c -= 5;
            push(PCH, c);
        end
        drive(6'b100000);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 1) drive(6'b0);
            if (change_pulse) begin
                seen = 1'b1;
                break;
            end
        end
        drive(6'b0);
        check("refund_started", seen, 1);
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("async_rst_credit", credit, 0);
        check("async_rst_change", change_pulse, 0);
        settle(3);
        exp_q.delete();
        m_credit = 0;
        reset = 1'b1;
        prev_credit = credit;
        mon_en = 1'b1;
        @(negedge clk);
        check("post_rst_credit", credit, 0);
        act_coin(1'b0, 1'b1);
    endtask

    initial begin
        int kind;
        int cm;
        int bl;
        bit rsp;
        reset = 1'b0;
        settle(3);
        check("rst_credit", credit, 0);
        check("rst_pulses", {B1, B2, B3, change_pulse, coin_reject, err}, 0);
        reset = 1'b1;
        prev_credit = credit;
        m_credit = 0;
        mon_en = 1'b1;
        @(negedge clk);

        // Directed scenarios
        act_coin(1'b0, 1'b1);
        act_coin(1'b1, 1'b0);
        act_sel(3'b010, 1'b0, 1'b1, 20, 1'b0);   // B2, credit 0
        act_coin(1'b0, 1'b1);
        act_sel(3'b100, 1'b0, 1'b1, 5, 1'b0);    // sel3 at 10: ignored
        act_coin(1'b0, 1'b1);
        act_sel(3'b101, 1'b0, 1'b1, 6, 1'b0);    // sel1+sel3 at 20: B1 only
        act_sel(3'b000, 1'b1, 1'b0, 0, 1'b0);    // refund the 10
        repeat (6) act_coin(1'b0, 1'b1);         // 50, then reject
        act_sel(3'b000, 1'b1, 1'b0, 0, 1'b0);    // 10 change pulses
        act_coin(1'b1, 1'b1);                    // simultaneous coins: 15
        act_sel(3'b001, 1'b0, 1'b0, 0, 1'b0);    // timeout, credit back to 15
        act_coin(1'b0, 1'b1);
        act_sel(3'b001, 1'b0, 1'b1, 20, 1'b1);   // coin during brewing
        act_sel(3'b111, 1'b1, 1'b0, 0, 1'b0);    // cancel beats selections

        // Randomised traffic
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                cm = $urandom_range(1, 3);
                act_coin(cm[0], cm[1]);
            end else begin
                rsp = ($urandom_range(0, 3) != 0);
                bl  = $urandom_range(1, 25);
                act_sel(3'($urandom_range(1, 7)), ($urandom_range(0, 5) == 0), rsp, bl,
                        rsp && (bl >= 12) && ($urandom_range(0, 1) == 1));
            end
        end

        reset_mid_refund();

        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cafea_credit.md
Name: cafea_credit

Overview:
- Payment and selection front-end placed directly upstream of the coffee-machine FSM (`cafea`).
- Synchronises and edge-detects raw coin and selection buttons, then accumulates credit.
- When credit covers the chosen drink, it deducts the price and issues a one-cycle B1/B2/B3 pulse to the FSM.
- Returns leftover credit as change pulses on cancel, and uses the FSM's busy indication to refund a selection the FSM never accepts.

Parameters:
- PRICE1, 10, price of drink 1 (drives B1), in credit units.
- PRICE2, 15, price of drink 2 (drives B2).
- PRICE3, 20, price of drink 3 (drives B3).
- CREDIT_MAX, 50, maximum credit held; coins that would exceed it are rejected.
- CHANGE_UNIT, 5, value of one change_pulse.
- TIMEOUT, 8, cycles to wait for busy after a B pulse.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- coin5  input  1  raw level from the 5-unit coin sensor, asynchronous.
- coin10  input  1  raw level from the 10-unit coin sensor, asynchronous.
- sel1  input  1  raw drink-1 button, asynchronous.
- sel2  input  1  raw drink-2 button, asynchronous.
- sel3  input  1  raw drink-3 button, asynchronous.
- cancel  input  1  raw cancel/refund button, asynchronous.
- busy  input  1  high while the coffee FSM is brewing; synchronous to clk.
- B1  output  1  one-cycle selection pulse to the FSM.
- B2  output  1  one-cycle selection pulse to the FSM.
- B3  output  1  one-cycle selection pulse to the FSM.
- credit  output  8  current credit, unsigned.
- change_pulse  output  1  one pulse per CHANGE_UNIT returned.
- coin_reject  output  1  one-cycle pulse when a coin is refused.
- err  output  1  one-cycle pulse on a busy timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - credit=0; B1, B2, B3, change_pulse, coin_reject and err all 0.
  - State=IDLE; synchroniser flops cleared.
- Inputs:
  - Every raw input passes a 2-flop synchroniser, then rising-edge detection. Each press produces exactly one internal event, 3 cycles after the edge.
  - Holding a button produces no repeat events.
- Coin events (accepted in every state except REFUND):
  - If credit+value <= CREDIT_MAX: credit += value on the next cycle.
  - Otherwise: credit is unchanged and coin_reject pulses for one cycle.
  - coin5 and coin10 together: coin10 is processed first, then coin5 on the following cycle (queued, never dropped). Each coin is checked against CREDIT_MAX independently.
- States:
  - IDLE:
    - Selection events are evaluated with priority sel1 > sel2 > sel3; only the highest-priority simultaneous selection is acted on and the rest are discarded.
    - If credit >= PRICEn: credit -= PRICEn, latch n, go to ISSUE.
    - If credit < PRICEn: ignore and stay in IDLE.
    - Cancel with credit>0: go to REFUND. Cancel with credit=0: ignored.
    - Cancel and a selection together: cancel wins.
  - ISSUE:
    - Assert the latched Bn for exactly one cycle, then go to WAIT_BUSY with the timeout counter = 0.
  - WAIT_BUSY:
    - busy=1: go to WAIT_DONE.
    - After TIMEOUT cycles without busy: restore credit += PRICEn (saturating at 8'hFF), pulse err for one cycle, go to IDLE.
  - WAIT_DONE:
    - busy=0: go to IDLE.
    - Selections and cancel are ignored in WAIT_BUSY and WAIT_DONE; coins are still accepted.
  - REFUND:
    - Repeats a 2-cycle pattern: change_pulse=1 for one cycle with credit -= CHANGE_UNIT on the same edge, then change_pulse=0 for one cycle.
    - When credit < CHANGE_UNIT: the residue is cleared to 0 and the block goes to IDLE. The residue cannot occur with the default parameters.
    - Coins, selections and cancel are ignored during REFUND; a coin inserted now is not credited.
- Outputs are registered.
- At most one of B1, B2, B3 is high in any cycle, and never while in REFUND.
- Reset mid-operation: any in-flight pulse is aborted, credit is lost (0), and the block is in IDLE on the first clock after release.

Test Plan:
- Reset, then coin10 and coin5 edges 10 cycles apart, then sel2 -> credit 10, then 15, then 0; B2 high for exactly 1 cycle; busy=1 for 20 cycles then 0 -> back in IDLE.
- Credit 10, sel3 pressed -> no B pulse, credit stays 10.
- sel1 and sel3 pressed in the same cycle with credit 20 -> only B1 pulses, credit 10.
- Five coin10 events then a sixth coin10 -> credit 50; sixth coin gives coin_reject, credit stays 50; cancel -> 10 change_pulse pulses spaced 2 cycles apart, credit 0.
- Credit 15, sel1, busy held 0 -> B1 pulses, then err after 8 cycles, credit back to 15.
- During WAIT_DONE, coin5 accepted (credit +5) and sel1 ignored; reset=0 asserted mid-REFUND -> credit 0 and change_pulse 0 immediately, without waiting for a clock.
